// File: rtl/slice_seq_adder.sv
// slice_seq_adder: multi-cycle WIDTH-bit adder that time-shares one SLICE-bit
// ripple-carry slice over WIDTH/SLICE clock cycles, with a registered carry
// linking consecutive slices. valid/ready handshake on both sides.
module slice_seq_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             busy
);

    localparam int NSL   = WIDTH / SLICE;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx;

    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_s;
    logic [SLICE:0]   sl_c;
    logic             last_slice;

    // The single shared slice: operands picked out of the latched words by idx
    assign sl_a       = a_r[idx*SLICE +: SLICE];
    assign sl_b       = b_r[idx*SLICE +: SLICE];
    assign sl_c[0]    = carry_r;
    assign last_slice = (idx == IDX_W'(NSL - 1));

    // Ripple chain of full-adder cells, one per slice bit
    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign sl_s[i]   = sl_a[i] ^ sl_b[i] ^ sl_c[i];
        assign sl_c[i+1] = (sl_a[i] & sl_b[i]) | (sl_c[i] & (sl_a[i] ^ sl_b[i]));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; rst is excluded from the IDLE accept via the register reset
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)   state_nxt = RUN;
            RUN:  if (last_slice) state_nxt = DONE;
            DONE: if (out_ready)  state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE) & ~rst;
        busy      = (state == RUN);
        out_valid = (state == DONE);
    end

    // Operand capture; data-only registers, meaningful only after an accept
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && in_valid) begin
            a_r <= A;
            b_r <= B;
        end
    end

    // Slice sequencing: carry link, slice index and the accumulated result
    always_ff @(posedge clk) begin
        if (rst) begin
            S       <= '0;
            Cout    <= 1'b0;
            idx     <= '0;
            carry_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        S       <= '0;
                        Cout    <= 1'b0;
                        idx     <= '0;
                        carry_r <= Cin;
                    end
                end
                RUN: begin
                    S[idx*SLICE +: SLICE] <= sl_s;
                    carry_r               <= sl_c[SLICE];
                    idx                   <= idx + 1'b1;
                    if (last_slice) begin
                        Cout <= sl_c[SLICE];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slice_seq_adder.sv
// Directed and randomized self-checking bench for slice_seq_adder (defaults:
// WIDTH=16, SLICE=4, so four slice passes per operation).
module tb_slice_seq_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        Cout;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    slice_seq_adder #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand bundle in IDLE, take the accept edge, then scramble inputs
    task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        Cin      = c;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        A        = 16'($urandom);
        B        = 16'($urandom);
        Cin      = 1'($urandom);
    endtask

    // Wait (bounded) for out_valid, checking latency, busy duration and result
    task automatic wait_done(input string tag, input logic [15:0] es, input logic ec);
        int lat   = 0;
        int bcnt  = 0;
        while (!out_valid && lat < 20) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'd4);
        chk({tag, ".busy_cycles"}, 32'(bcnt), 32'd4);
        chk({tag, ".S"}, 32'(S), 32'(es));
        chk({tag, ".Cout"}, 32'(Cout), 32'(ec));
    endtask

    // Stall the consumer for n cycles while noise is driven on the input side
    task automatic hold_done(input string tag, input logic [15:0] es, input logic ec, input int n);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom);
            A        = 16'($urandom);
            B        = 16'($urandom);
            Cin      = 1'($urandom);
            tick();
            chk({tag, ".hold_S"}, 32'(S), 32'(es));
            chk({tag, ".hold_Cout"}, 32'(Cout), 32'(ec));
            chk({tag, ".hold_out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic release_done(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".rel_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".rel_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        string       tag;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] es;
        logic        ec;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"zero",    16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{"ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{"0fff_p1", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
        vecs[3] = '{"00f0",    16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0};
        vecs[4] = '{"cin_ffff",16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[5] = '{"1234",    16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.S", 32'(S), 32'd0);
        chk("rst.Cout", 32'(Cout), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst.in_ready", 32'(in_ready), 32'd1);

        // Directed vectors
        foreach (vecs[i]) begin
            start_op(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].c);
            wait_done(vecs[i].tag, vecs[i].es, vecs[i].ec);
            release_done(vecs[i].tag);
        end

        // Backpressure, then back-to-back accept right after the handshake
        start_op("bp", 16'h1234, 16'h4321, 1'b1);
        wait_done("bp", 16'h5556, 1'b0);
        hold_done("bp", 16'h5556, 1'b0, 5);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A         = 16'h0FFF;
        B         = 16'h0001;
        Cin       = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("bp.k_out_valid", 32'(out_valid), 32'd0);
        chk("bp.k_busy", 32'(busy), 32'd0);
        chk("bp.k_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        A        = 16'hAAAA;
        B        = 16'h5555;
        chk("bp.k1_busy", 32'(busy), 32'd1);
        wait_done("bp2", 16'h1000, 1'b0);
        release_done("bp2");

        // Reset in the second RUN cycle discards the operation
        start_op("rstrun", 16'hFFFF, 16'h0001, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk("rstrun.in_ready", 32'(in_ready), 32'd0);
        chk("rstrun.busy", 32'(busy), 32'd0);
        chk("rstrun.out_valid", 32'(out_valid), 32'd0);
        chk("rstrun.S", 32'(S), 32'd0);
        chk("rstrun.Cout", 32'(Cout), 32'd0);
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (out_valid) seen++;
            end
            chk("rstrun.no_result", 32'(seen), 32'd0);
        end
        chk("rstrun.idle_ready", 32'(in_ready), 32'd1);
        start_op("msb", 16'h8000, 16'h8000, 1'b0);
        wait_done("msb", 16'h0000, 1'b1);
        release_done("msb");

        // Randomized operands with random gaps on both sides
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rc;
            logic [16:0] sum;
            int          gap;
            int          hold;
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom);
            sum  = 17'(ra) + 17'(rb) + 17'(rc);
            gap  = int'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            start_op("rnd", ra, rb, rc);
            wait_done("rnd", sum[15:0], sum[16]);
            if (hold > 0) hold_done("rnd", sum[15:0], sum[16], hold);
            release_done("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
